id_ex_sched: RTL and testbench
==============================

Name: id_ex_sched

Overview:
- Decode-to-execute scheduler for the RV32I 5-stage pipeline.
- Classifies the ID-stage instruction's opcode, selects the matching immediate from the five immediate-generator outputs, and loads the ID/EX pipeline register.
- Detects load-use hazards and inserts exactly one bubble.
- Arbitrates flush, EX back-pressure and hazard stalls, and counts hazard stalls for performance monitoring.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid_i  in  1  IF/ID register holds a valid instruction.
- id_instr_i  in  32  IF/ID instruction word.
- id_pc_i  in  32  IF/ID PC.
- i_imme_i, s_imme_i, sb_imme_i, uj_imme_i, u_imme_i  in  32 each  immediate-generator outputs for id_instr_i.
- ex_stall_i  in  1  EX/MEM cannot accept; hold ID/EX.
- flush_i  in  1  branch/jump redirect; kill ID.
- id_stall_o  out  1  combinational; IF and IF/ID must hold.
- ex_valid_o  out  1  ID/EX holds a valid instruction.
- ex_pc_o  out  32  registered PC.
- ex_imm_o  out  32  registered selected immediate.
- ex_imm_sel_o  out  3  registered format: 0 NONE, 1 I, 2 S, 3 B, 4 J, 5 U.
- ex_rd_o, ex_rs1_o, ex_rs2_o  out  5 each  registered register fields; zeroed when unused.
- ex_is_load_o  out  1  registered; opcode is 0000011.
- ex_illegal_o  out  1  registered; opcode not in the RV32I set.
- stall_cnt_o  out  STALL_CNT_W  load-use stall count, saturating.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all registered outputs clear to 0, including stall_cnt_o. Reset mid-stall drops the pending bubble and the held entry.
- Opcode to format mapping:
  - 0010011, 0000011, 1100111, 0001111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1101111 -> J.
  - 0110111, 0010111 -> U.
  - 0110011 -> NONE, imm 0.
  - Any other opcode -> NONE, imm 0, illegal=1.
- Register-field usage:
  - rs1 is used by every format except U, J and illegal.
  - rs2 is used by R (0110011), S and B only.
  - rd is written by every format except S, B and illegal.
  - Unused fields register as 0.
- Load-use hazard: hazard = id_valid_i & ex_valid_o & ex_is_load_o & (ex_rd_o != 0) & ((rs1 used & rs1 == ex_rd_o) | (rs2 used & rs2 == ex_rd_o)).
- Next-state priority, evaluated each clk:
  1. flush_i: ex_valid_o <= 0; id_stall_o = 0. flush overrides ex_stall_i.
  2. ex_stall_i: ID/EX holds all fields; id_stall_o = 1.
  3. hazard: ID/EX loads a bubble (ex_valid_o <= 0, other fields 0); id_stall_o = 1; stall_cnt_o increments.
  4. Otherwise: ID/EX loads the decoded ID instruction; ex_valid_o <= id_valid_i; id_stall_o = 0.
- If id_valid_i=0, the load in case 4 is a bubble: all fields are 0.
- Latency: one cycle from ID to EX.
- A hazard resolves after exactly one bubble, because the bubble has ex_valid_o=0.
- When ex_stall_i and hazard coincide, only the EX stall applies and the counter does not increment. The hazard is re-evaluated each cycle.
- The counter saturates at all-ones and does not wrap.
- id_stall_o is combinational from the current inputs and registers. It has no combinational path from flush_i into the ID/EX data registers.

Test Plan:
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x2 (0x00228333), back-to-back -> after the LW, one cycle with id_stall_o=1 and ex_valid_o=0; ADD enters EX the next cycle with ex_rs1_o=5, ex_rs2_o=2, ex_imm_sel_o=0; stall_cnt_o=1.
- LW x8 (0x0000A403) then LUI x7,0x12345 (0x123453B7, whose rs1 field bits equal 8) -> no stall; ex_imm_o=0x12345000, ex_imm_sel_o=5, ex_rs1_o=0.
- BEQ x0,x0,-4 (0xFE000EE3) with the generator driven by the same instruction word -> ex_imm_o=0xFFFFFFFC, ex_imm_sel_o=3, ex_rd_o=0.
- Load-use hazard and flush_i=1 in the same cycle -> ex_valid_o=0, id_stall_o=0, stall_cnt_o unchanged.
- ex_stall_i=1 for 3 cycles while holding ADDI -> ex_* outputs stable for all 3 cycles; id_stall_o=1; no counter change.
- Opcode 0x7F -> ex_illegal_o=1, ex_imm_o=0. Separately, rst_n=0 mid-hazard -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/id_ex_sched.sv
// Decode-to-execute scheduler: classifies the ID instruction, picks its immediate,
// loads the ID/EX register and inserts a single bubble on load-use hazards.
module id_ex_sched #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    input  logic [31:0]            id_instr_i,
    input  logic [31:0]            id_pc_i,
    input  logic [31:0]            i_imme_i,
    input  logic [31:0]            s_imme_i,
    input  logic [31:0]            sb_imme_i,
    input  logic [31:0]            uj_imme_i,
    input  logic [31:0]            u_imme_i,
    input  logic                   ex_stall_i,
    input  logic                   flush_i,
    output logic                   id_stall_o,
    output logic                   ex_valid_o,
    output logic [31:0]            ex_pc_o,
    output logic [31:0]            ex_imm_o,
    output logic [2:0]             ex_imm_sel_o,
    output logic [4:0]             ex_rd_o,
    output logic [4:0]             ex_rs1_o,
    output logic [4:0]             ex_rs2_o,
    output logic                   ex_is_load_o,
    output logic                   ex_illegal_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_J    = 3'd4,
        FMT_U    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]  opcode;
    fmt_e        fmt;
    logic        illegal;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_used;
    logic [31:0] imm_sel;
    logic [4:0]  rd_dec;
    logic [4:0]  rs1_dec;
    logic [4:0]  rs2_dec;
    logic        hazard;

    assign opcode = id_instr_i[6:0];

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                                      fmt = FMT_S;
            OP_BRANCH:                                     fmt = FMT_B;
            OP_JAL:                                        fmt = FMT_J;
            OP_LUI, OP_AUIPC:                              fmt = FMT_U;
            OP_REG:                                        fmt = FMT_NONE;
            default:                                       illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm_sel = 32'd0;
        case (fmt)
            FMT_I:   imm_sel = i_imme_i;
            FMT_S:   imm_sel = s_imme_i;
            FMT_B:   imm_sel = sb_imme_i;
            FMT_J:   imm_sel = uj_imme_i;
            FMT_U:   imm_sel = u_imme_i;
            default: imm_sel = 32'd0;
        endcase
    end

    assign rs1_used = !(fmt == FMT_U || fmt == FMT_J || illegal);
    assign rs2_used = (opcode == OP_REG) || (fmt == FMT_S) || (fmt == FMT_B);
    assign rd_used  = !(fmt == FMT_S || fmt == FMT_B || illegal);

    assign rd_dec  = rd_used  ? id_instr_i[11:7]  : 5'd0;
    assign rs1_dec = rs1_used ? id_instr_i[19:15] : 5'd0;
    assign rs2_dec = rs2_used ? id_instr_i[24:20] : 5'd0;

    // Uses the zeroed fields, so an unused field can never match ex_rd_o.
    assign hazard = id_valid_i && ex_valid_o && ex_is_load_o && (ex_rd_o != 5'd0) &&
                    ((rs1_used && rs1_dec == ex_rd_o) || (rs2_used && rs2_dec == ex_rd_o));

    assign id_stall_o = !flush_i && (ex_stall_i || hazard);

    // Valid bit carries the flush; data registers only see stall/hazard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_o <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (!ex_stall_i) begin
            ex_valid_o <= id_valid_i && !hazard;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_pc_o      <= 32'd0;
            ex_imm_o     <= 32'd0;
            ex_imm_sel_o <= 3'd0;
            ex_rd_o      <= 5'd0;
            ex_rs1_o     <= 5'd0;
            ex_rs2_o     <= 5'd0;
            ex_is_load_o <= 1'b0;
            ex_illegal_o <= 1'b0;
        end else if (!ex_stall_i) begin
            if (hazard || !id_valid_i) begin
                ex_pc_o      <= 32'd0;
                ex_imm_o     <= 32'd0;
                ex_imm_sel_o <= 3'd0;
                ex_rd_o      <= 5'd0;
                ex_rs1_o     <= 5'd0;
                ex_rs2_o     <= 5'd0;
                ex_is_load_o <= 1'b0;
                ex_illegal_o <= 1'b0;
            end else begin
                ex_pc_o      <= id_pc_i;
                ex_imm_o     <= imm_sel;
                ex_imm_sel_o <= fmt;
                ex_rd_o      <= rd_dec;
                ex_rs1_o     <= rs1_dec;
                ex_rs2_o     <= rs2_dec;
                ex_is_load_o <= (opcode == OP_LOAD);
                ex_illegal_o <= illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (!flush_i && !ex_stall_i && hazard &&
                     stall_cnt_o != {STALL_CNT_W{1'b1}}) begin
            stall_cnt_o <= stall_cnt_o + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_sched.sv
// Bench for id_ex_sched: directed scenarios plus randomized traffic against a
// behavioural model of the ID/EX register, hazard rule and stall counter.
module tb_id_ex_sched;

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [31:0]   id_instr, id_pc;
    logic [31:0]   i_imm, s_imm, sb_imm, uj_imm, u_imm;
    logic          ex_stall, flush;
    logic          id_stall;
    logic          ex_valid;
    logic [31:0]   ex_pc, ex_imm;
    logic [2:0]    ex_imm_sel;
    logic [4:0]    ex_rd, ex_rs1, ex_rs2;
    logic          ex_is_load, ex_illegal;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Expected ID/EX contents; m_x marks data fields left unspecified by a flush.
    logic          m_valid, m_load, m_ill, m_x;
    logic [31:0]   m_pc, m_imm;
    logic [2:0]    m_sel;
    logic [4:0]    m_rd, m_rs1, m_rs2;
    logic [CW-1:0] m_cnt;
    logic          exp_stall, obs_stall, stall_sampled;

    always #5 clk = ~clk;

    id_ex_sched #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_instr_i(id_instr), .id_pc_i(id_pc),
        .i_imme_i(i_imm), .s_imme_i(s_imm), .sb_imme_i(sb_imm),
        .uj_imme_i(uj_imm), .u_imme_i(u_imm),
        .ex_stall_i(ex_stall), .flush_i(flush),
        .id_stall_o(id_stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
        .ex_imm_o(ex_imm), .ex_imm_sel_o(ex_imm_sel),
        .ex_rd_o(ex_rd), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
        .ex_is_load_o(ex_is_load), .ex_illegal_o(ex_illegal),
        .stall_cnt_o(stall_cnt)
    );

    // Format code from the opcode table: 0 NONE, 1 I, 2 S, 3 B, 4 J, 5 U.
    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: return 3'd1;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h6F: return 3'd4;
            7'h37, 7'h17: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (fmt_of(op) != 3'd0) || (op == 7'h33);
    endfunction

    // Drive an ID instruction with the immediates a real generator would produce.
    task automatic set_id(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        id_valid = v;
        id_instr = ins;
        id_pc    = pc;
        i_imm    = {{20{ins[31]}}, ins[31:20]};
        s_imm    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        sb_imm   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        uj_imm   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        u_imm    = {ins[31:12], 12'd0};
    endtask

    task automatic model_step();
        logic [6:0] op;
        logic [2:0] f;
        logic ill, u1, u2, ud, haz;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] imm;
        op  = id_instr[6:0];
        f   = fmt_of(op);
        ill = !is_legal(op);
        u1  = !(f == 3'd5 || f == 3'd4 || ill);
        u2  = (op == 7'h33) || f == 3'd2 || f == 3'd3;
        ud  = !(f == 3'd2 || f == 3'd3 || ill);
        rd  = ud ? id_instr[11:7]  : 5'd0;
        rs1 = u1 ? id_instr[19:15] : 5'd0;
        rs2 = u2 ? id_instr[24:20] : 5'd0;
        case (f)
            3'd1: imm = i_imm;
            3'd2: imm = s_imm;
            3'd3: imm = sb_imm;
            3'd4: imm = uj_imm;
            3'd5: imm = u_imm;
            default: imm = 32'd0;
        endcase
        haz = id_valid && m_valid && m_load && m_rd != 0 &&
              ((u1 && rs1 == m_rd) || (u2 && rs2 == m_rd));
        exp_stall = !flush && (ex_stall || haz);
        if (!rst_n) begin
            {m_valid, m_load, m_ill, m_x} = 4'b0;
            m_pc = 0; m_imm = 0; m_sel = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
        end else begin
            if (!flush && !ex_stall && haz && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            if (!ex_stall) begin
                if (haz || !id_valid) begin
                    m_pc = 0; m_imm = 0; m_sel = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
                    m_load = 0; m_ill = 0;
                end else begin
                    m_pc = id_pc; m_imm = imm; m_sel = f; m_rd = rd; m_rs1 = rs1;
                    m_rs2 = rs2; m_load = (op == 7'h03); m_ill = ill;
                end
            end
            m_x     = flush ? 1'b1 : (ex_stall ? m_x : 1'b0);
            m_valid = flush ? 1'b0 : (ex_stall ? m_valid : (id_valid && !haz));
        end
    endtask

    // One clock: sample id_stall at negedge, advance model, settle after posedge.
    task automatic cycle();
        @(negedge clk);
        obs_stall     = id_stall;
        stall_sampled = rst_n;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 32'd0, 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 32'h0000A283, 32'h40);
        cycle();
        checks++;
        if ({ex_valid, ex_pc, ex_imm, ex_imm_sel, ex_rd, ex_rs1, ex_rs2, ex_is_load,
             ex_illegal, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ex_valid=%b ex_pc=%h ex_imm=%h cnt=%0d, all zero required",
                     ex_valid, ex_pc, ex_imm, stall_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 32'h0000A283, 32'h100);
        cycle();
        set_id(1'b1, 32'h00228333, 32'h104);
        cycle();
        checks++;
        if (obs_stall !== 1'b1 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: id_stall=%b ex_valid=%b, required 1 0", obs_stall, ex_valid);
        end
        cycle();
        checks++;
        if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rs2 !== 5'd2 ||
            ex_imm_sel !== 3'd0 || ex_pc !== 32'h104 || ex_rd !== 5'd6 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_add: stall=%b v=%b rs1=%0d rs2=%0d sel=%0d pc=%h rd=%0d cnt=%0d, required 0 1 5 2 0 104 6 1",
                     obs_stall, ex_valid, ex_rs1, ex_rs2, ex_imm_sel, ex_pc, ex_rd, stall_cnt);
        end
    endtask

    task automatic test_lui_no_hazard();
        do_reset();
        set_id(1'b1, 32'h0000A403, 32'h200);
        cycle();
        checks++;
        if (ex_is_load !== 1'b1 || ex_rd !== 5'd8 || ex_imm_sel !== 3'd1) begin
            errors++;
            $display("FAIL lw_x8: load=%b rd=%0d sel=%0d, required 1 8 1", ex_is_load, ex_rd, ex_imm_sel);
        end
        set_id(1'b1, 32'h123453B7, 32'h204);
        cycle();
        checks++;
        if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || ex_imm !== 32'h12345000 ||
            ex_imm_sel !== 3'd5 || ex_rs1 !== 5'd0 || ex_rd !== 5'd7 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL lui_no_stall: stall=%b v=%b imm=%h sel=%0d rs1=%0d rd=%0d cnt=%0d, required 0 1 12345000 5 0 7 0",
                     obs_stall, ex_valid, ex_imm, ex_imm_sel, ex_rs1, ex_rd, stall_cnt);
        end
    endtask

    task automatic test_branch_imm();
        do_reset();
        set_id(1'b1, 32'hFE000EE3, 32'h300);
        cycle();
        checks++;
        if (ex_imm !== 32'hFFFFFFFC || ex_imm_sel !== 3'd3 || ex_rd !== 5'd0 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL beq_imm: imm=%h sel=%0d rd=%0d v=%b, required fffffffc 3 0 1",
                     ex_imm, ex_imm_sel, ex_rd, ex_valid);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        set_id(1'b1, 32'h0000A283, 32'h400);
        cycle();
        set_id(1'b1, 32'h00228333, 32'h404);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (obs_stall !== 1'b0 || ex_valid !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL flush_hazard: stall=%b v=%b cnt=%0d, required 0 0 0", obs_stall, ex_valid, stall_cnt);
        end
    endtask

    task automatic test_ex_stall_hold();
        logic [31:0] pc0, imm0;
        do_reset();
        set_id(1'b1, 32'h00508093, 32'h500);
        cycle();
        pc0  = 32'h500;
        imm0 = 32'd5;
        ex_stall = 1'b1;
        set_id(1'b1, 32'h0000A283, 32'h504);
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (obs_stall !== 1'b1 || ex_valid !== 1'b1 || ex_pc !== pc0 || ex_imm !== imm0 ||
                ex_imm_sel !== 3'd1 || ex_rd !== 5'd1 || ex_rs1 !== 5'd1 || stall_cnt !== 4'd0) begin
                errors++;
                $display("FAIL ex_stall_hold[%0d]: stall=%b v=%b pc=%h imm=%h sel=%0d rd=%0d cnt=%0d, required 1 1 500 5 1 1 0",
                         k, obs_stall, ex_valid, ex_pc, ex_imm, ex_imm_sel, ex_rd, stall_cnt);
            end
        end
        ex_stall = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        set_id(1'b1, 32'hFFFFF07F, 32'h600);
        cycle();
        checks++;
        if (ex_illegal !== 1'b1 || ex_imm !== 32'd0 || ex_imm_sel !== 3'd0 ||
            ex_rd !== 5'd0 || ex_rs1 !== 5'd0 || ex_rs2 !== 5'd0) begin
            errors++;
            $display("FAIL illegal_op: ill=%b imm=%h sel=%0d rd=%0d rs1=%0d rs2=%0d, required 1 0 0 0 0 0",
                     ex_illegal, ex_imm, ex_imm_sel, ex_rd, ex_rs1, ex_rs2);
        end
    endtask

    task automatic test_reset_mid_hazard();
        do_reset();
        set_id(1'b1, 32'h0000A283, 32'h700);
        cycle();
        set_id(1'b1, 32'h00228333, 32'h704);
        cycle();
        rst_n = 1'b0;
        cycle();
        checks++;
        if ({ex_valid, ex_pc, ex_imm, ex_imm_sel, ex_rd, ex_rs1, ex_rs2, ex_is_load,
             ex_illegal, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_hazard: v=%b pc=%h rd=%0d load=%b cnt=%0d, all zero required",
                     ex_valid, ex_pc, ex_rd, ex_is_load, stall_cnt);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
            errors++;
            $display("FAIL after_reset_no_bubble: stall=%b v=%b rd=%0d, required 0 1 6", obs_stall, ex_valid, ex_rd);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            set_id(1'b1, 32'h0000A283, 32'h800);
            cycle();
            set_id(1'b1, 32'h00228333, 32'h804);
            cycle();
            checks++;
            if (stall_cnt !== ((k > 15) ? 4'd15 : 4'(k))) begin
                errors++;
                $display("FAIL stall_cnt_sat[%0d]: cnt=%0d, required %0d", k, stall_cnt, (k > 15) ? 15 : k);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        logic [31:0] ins;
        ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h03};
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n    = ($urandom_range(0, 99) >= 2);
            ex_stall = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 10);
            if (!(exp_stall && $urandom_range(0, 99) < 70)) begin
                ins = $urandom;
                ins[6:0]   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
                ins[11:7]  = 5'($urandom_range(0, 5));
                ins[19:15] = 5'($urandom_range(0, 5));
                ins[24:20] = 5'($urandom_range(0, 5));
                id_valid = ($urandom_range(0, 99) < 85);
                id_instr = ins;
                id_pc    = $urandom;
                i_imm = $urandom; s_imm = $urandom; sb_imm = $urandom;
                uj_imm = $urandom; u_imm = $urandom;
            end
            cycle();
            if (stall_sampled) begin
                checks++;
                if (obs_stall !== exp_stall) begin
                    errors++;
                    $display("FAIL rand_id_stall[%0d]: got %b, required %b", n, obs_stall, exp_stall);
                end
            end
            checks++;
            if (ex_valid !== m_valid || stall_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_valid_cnt[%0d]: v=%b cnt=%0d, required %b %0d", n, ex_valid, stall_cnt, m_valid, m_cnt);
            end
            if (!m_x) begin
                checks++;
                if (ex_pc !== m_pc || ex_imm !== m_imm || ex_imm_sel !== m_sel || ex_rd !== m_rd ||
                    ex_rs1 !== m_rs1 || ex_rs2 !== m_rs2 || ex_is_load !== m_load || ex_illegal !== m_ill) begin
                    errors++;
                    $display("FAIL rand_fields[%0d]: pc=%h imm=%h sel=%0d rd=%0d rs1=%0d rs2=%0d ld=%b ill=%b, required %h %h %0d %0d %0d %0d %b %b",
                             n, ex_pc, ex_imm, ex_imm_sel, ex_rd, ex_rs1, ex_rs2, ex_is_load, ex_illegal,
                             m_pc, m_imm, m_sel, m_rd, m_rs1, m_rs2, m_load, m_ill);
                end
            end
        end
        rst_n = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        exp_stall = 1'b0;
        test_reset();
        test_load_use();
        test_lui_no_hazard();
        test_branch_imm();
        test_flush_hazard();
        test_ex_stall_hold();
        test_illegal();
        test_reset_mid_hazard();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
